// File: rtl/spi_page_program_seq.sv
// SPI flash page-program sequencer: WREN, CS gap, then PP (cmd, 24-bit addr, data),
// followed by a fixed program-time wait.
module spi_page_program_seq #(
  parameter logic [7:0]  GAP_CYC = 8'd10,
  parameter logic [31:0] TPP_CYC = 32'd150_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  output logic        data_req,
  input  logic [7:0]  wr_data,
  output logic        spi_start,
  output logic [1:0]  spi_cmd,
  output logic [7:0]  spi_width,
  output logic [7:0]  spi_wrdata,
  input  logic        spi_done,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, WREN, GAP, CMD, ADDR, DATA, WAIT, DONE
  } state_t;

  state_t      state;
  logic [23:0] addr_q;
  logic [8:0]  cnt;
  logic [1:0]  idx;
  logic [7:0]  gap_cnt;
  logic [31:0] wait_cnt;
  logic        pend;
  logic [1:0]  dph;
  logic        xfer_end;

  // spi_done only counts while a byte is actually in flight
  assign xfer_end  = pend && spi_done;
  assign spi_width = 8'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= 24'h0;
      cnt        <= 9'd0;
      idx        <= 2'd0;
      gap_cnt    <= 8'd0;
      wait_cnt   <= 32'd0;
      pend       <= 1'b0;
      dph        <= 2'd0;
      spi_start  <= 1'b0;
      spi_cmd    <= 2'd0;
      spi_wrdata <= 8'h00;
      data_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      data_req  <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= addr;
            cnt        <= (len == 9'd0) ? 9'd256 : len;
            busy       <= 1'b1;
            spi_start  <= 1'b1;
            spi_wrdata <= 8'h06;
            spi_cmd    <= 2'd2;
            pend       <= 1'b1;
            state      <= WREN;
          end
        end
        WREN: begin
          if (xfer_end) begin
            pend    <= 1'b0;
            gap_cnt <= 8'd0;
            if (GAP_CYC == 8'd0) begin
              spi_start  <= 1'b1;
              spi_wrdata <= 8'h02;
              spi_cmd    <= 2'd1;
              pend       <= 1'b1;
              state      <= CMD;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_CYC - 8'd1) begin
            gap_cnt    <= 8'd0;
            spi_start  <= 1'b1;
            spi_wrdata <= 8'h02;
            spi_cmd    <= 2'd1;
            pend       <= 1'b1;
            state      <= CMD;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        CMD: begin
          if (xfer_end) begin
            idx        <= 2'd0;
            spi_start  <= 1'b1;
            spi_wrdata <= addr_q[23:16];
            spi_cmd    <= 2'd1;
            pend       <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (xfer_end) begin
            if (idx == 2'd2) begin
              pend     <= 1'b0;
              data_req <= 1'b1;
              dph      <= 2'd1;
              state    <= DATA;
            end else begin
              idx        <= idx + 2'd1;
              spi_start  <= 1'b1;
              spi_wrdata <= (idx == 2'd0) ? addr_q[15:8] : addr_q[7:0];
              spi_cmd    <= 2'd1;
              pend       <= 1'b1;
            end
          end
        end
        DATA: begin
          // dph: 1 = request out, 2 = byte valid on wr_data, 0 = in flight
          if (dph == 2'd1) begin
            dph <= 2'd2;
          end else if (dph == 2'd2) begin
            spi_wrdata <= wr_data;
            spi_cmd    <= (cnt == 9'd1) ? 2'd2 : 2'd1;
            spi_start  <= 1'b1;
            pend       <= 1'b1;
            dph        <= 2'd0;
          end else if (xfer_end) begin
            pend <= 1'b0;
            cnt  <= cnt - 9'd1;
            if (cnt == 9'd1) begin
              wait_cnt <= 32'd0;
              if (TPP_CYC == 32'd0) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                state <= WAIT;
              end
            end else begin
              data_req <= 1'b1;
              dph      <= 2'd1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == TPP_CYC - 32'd1) begin
            wait_cnt <= 32'd0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_page_program_seq.sv
// Randomized bench for spi_page_program_seq with a byte-shifter model
// and a transaction-level expected-stream model.
module tb_spi_page_program_seq;

  localparam int G = 4;
  localparam int T = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] addr;
  logic [8:0]  len;
  logic        data_req;
  logic [7:0]  wr_data;
  logic        spi_start;
  logic [1:0]  spi_cmd;
  logic [7:0]  spi_width;
  logic [7:0]  spi_wrdata;
  logic        spi_done;
  logic        busy;
  logic        done;

  spi_page_program_seq #(
    .GAP_CYC(8'(G)),
    .TPP_CYC(32'(T))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .data_req  (data_req),
    .wr_data   (wr_data),
    .spi_start (spi_start),
    .spi_cmd   (spi_cmd),
    .spi_width (spi_width),
    .spi_wrdata(spi_wrdata),
    .spi_done  (spi_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  int last_done = 0;
  int first_start = 0;
  logic [7:0] got_b[$];
  logic [1:0] got_c[$];
  int gaps[$];
  int dreq_cnt, didx, ovl, unstable, wbad;
  bit dreq_d = 1'b0;
  bit force_done = 1'b0;
  int fixed_lat = -1;
  logic [7:0] tx_data[256];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".spi_start"}, 32'(spi_start), 0);
    chk({tag, ".spi_cmd"}, 32'(spi_cmd), 0);
    chk({tag, ".spi_wrdata"}, 32'(spi_wrdata), 0);
    chk({tag, ".spi_width"}, 32'(spi_width), 8);
    chk({tag, ".data_req"}, 32'(data_req), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  // Byte shifter: accepts a byte on spi_start, answers spi_done after
  // a random latency; also serves wr_data the cycle after data_req.
  task automatic bus_model();
    bit outst = 1'b0;
    int lat = 0;
    logic [7:0] hb = 8'h0;
    logic [1:0] hc = 2'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_done) spi_done = 1'b0;
      if (force_done) begin
        spi_done = 1'b1;
        force_done = 1'b0;
      end
      if (spi_width !== 8'd8) wbad++;
      if (spi_start) begin
        if (outst) ovl++;
        if (got_b.size() == 0) first_start = cyc;
        got_b.push_back(spi_wrdata);
        got_c.push_back(spi_cmd);
        gaps.push_back(cyc - last_done);
        outst = 1'b1;
        hb = spi_wrdata;
        hc = spi_cmd;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else if (outst) begin
        if (spi_wrdata !== hb || spi_cmd !== hc) unstable++;
        if (lat == 0) begin
          spi_done = 1'b1;
          outst = 1'b0;
          last_done = cyc;
        end else begin
          lat--;
        end
      end
      if (dreq_d && didx < 256) begin
        wr_data = tx_data[didx];
        didx++;
      end else begin
        wr_data = 8'($urandom);
      end
      dreq_d = data_req;
    end
  endtask

  // mode 0: plain run, 1: start re-pulsed during ADDR, 2: reset in data byte 2
  task automatic run_seq(input logic [23:0] a, input logic [8:0] l,
                         input int mode);
    int n;
    int start_cyc;
    int busy_low;
    int extra;
    int act;
    bit seen;
    bit hit;
    bit poked;
    logic [7:0] exp_b[$];
    logic [1:0] exp_c[$];
    n = (l == 9'd0) ? 256 : int'(l);
    exp_b = {8'h06, 8'h02, a[23:16], a[15:8], a[7:0]};
    exp_c = {2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < n; i++) begin
      exp_b.push_back(tx_data[i]);
      exp_c.push_back((i == n - 1) ? 2'd2 : 2'd1);
    end
    got_b.delete();
    got_c.delete();
    gaps.delete();
    dreq_cnt = 0;
    didx = 0;
    ovl = 0;
    unstable = 0;
    wbad = 0;
    dreq_d = 1'b0;
    fixed_lat = (mode == 2) ? 3 : -1;
    busy_low = 0;
    extra = 0;
    seen = 1'b0;
    hit = 1'b0;
    poked = 1'b0;
    addr = a;
    len = l;
    start = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (k == 0) begin
        addr = 24'($urandom);
        len = 9'($urandom);
      end
      if (data_req) dreq_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_low++;
      if (mode == 1 && !poked && got_b.size() == 3) begin
        start = 1'b1;
        addr = a ^ 24'hA5A5A5;
        len = 9'd7;
        poked = 1'b1;
      end
      if (mode == 2 && got_b.size() == 7) begin
        rst_n = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    if (mode == 2) begin
      chk("rst_hit", 32'(hit), 1);
      @(negedge clk); #1;
      chk_reset("mid_rst");
      rst_n = 1'b1;
      act = 0;
      repeat (10) begin
        @(negedge clk); #1;
        if (spi_start || data_req || busy || done) act++;
      end
      chk("post_rst_quiet", 32'(act), 0);
      chk("post_rst_ovl", 32'(ovl), 0);
      fixed_lat = -1;
      return;
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_time", 32'(cyc - last_done), 32'(T + 1));
    chk("busy_at_done", 32'(busy), 0);
    repeat (6) begin
      @(negedge clk); #1;
      if (done || spi_start || data_req || busy) extra++;
    end
    chk("after_done_quiet", 32'(extra), 0);
    chk("nbytes", 32'(got_b.size()), 32'(n + 5));
    chk("ndata_req", 32'(dreq_cnt), 32'(n));
    chk("first_latency", 32'(first_start - start_cyc), 1);
    chk("busy_low", 32'(busy_low), 0);
    chk("overlap", 32'(ovl), 0);
    chk("unstable", 32'(unstable), 0);
    chk("width", 32'(wbad), 0);
    for (int i = 0; i < got_b.size() && i < n + 5; i++) begin
      chk($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
      chk($sformatf("cmd%0d", i), 32'(got_c[i]), 32'(exp_c[i]));
      if (i >= 1)
        chk($sformatf("gap%0d", i), 32'(gaps[i]),
            (i == 1) ? 32'(G + 1) : (i <= 4) ? 32'd1 : 32'd3);
    end
  endtask

  initial begin
    int act;
    rst_n = 1'b0;
    start = 1'b0;
    addr = 24'h0;
    len = 9'd0;
    wr_data = 8'h0;
    spi_done = 1'b0;
    fork
      bus_model();
    join_none
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    force_done = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (spi_start || data_req || busy || done) act++;
    end
    chk("stray_done_idle", 32'(act), 0);

    for (int i = 0; i < 4; i++) tx_data[i] = 8'hA0 + 8'(i);
    run_seq(24'h012345, 9'd4, 0);

    tx_data[0] = 8'($urandom);
    run_seq(24'($urandom), 9'd1, 0);

    for (int i = 0; i < 256; i++) tx_data[i] = 8'($urandom);
    run_seq(24'($urandom), 9'd0, 0);

    for (int i = 0; i < 5; i++) tx_data[i] = 8'($urandom);
    run_seq(24'hABCDEF, 9'd5, 1);

    for (int i = 0; i < 6; i++) tx_data[i] = 8'($urandom);
    run_seq(24'($urandom), 9'd6, 2);

    for (int i = 0; i < 3; i++) tx_data[i] = 8'($urandom);
    run_seq(24'($urandom), 9'd3, 0);

    for (int r = 0; r < 4; r++) begin
      int l;
      l = int'($urandom_range(1, 40));
      for (int i = 0; i < l; i++) tx_data[i] = 8'($urandom);
      run_seq(24'($urandom), 9'(l), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_page_program_seq.md
SPI_PAGE_PROGRAM_SEQ -- requirements
Module: spi_page_program_seq

Interface
REQ-001 SHALL have parameter GAP_CYC, default 8'd10, meaning the number of CS-high idle cycles between the WREN and PP transactions.
REQ-002 SHALL have parameter TPP_CYC, default 32'd150_000, meaning the number of page-program wait cycles after the last byte.
REQ-003 SHALL have port clk, input, 1, the divided system clock that also drives the byte shifter.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request that is sampled only in IDLE.
REQ-006 SHALL have port addr, input, 24, the flash byte address, sampled on an accepted start.
REQ-007 SHALL have port len, input, 9, the number of data bytes (1..256), sampled on an accepted start; 0 is treated as 256.
REQ-008 SHALL have port data_req, output, 1, a one-cycle pulse requesting the next data byte.
REQ-009 SHALL have port wr_data, input, 8, the data byte; it is valid on the cycle after data_req.
REQ-010 SHALL have port spi_start, output, 1, a one-cycle pulse that launches one byte transfer.
REQ-011 SHALL have port spi_cmd, output, 2, with 2'd1 = byte with CS held low afterwards and 2'd2 = last byte, release CS afterwards.
REQ-012 SHALL have port spi_width, output, 8, the transfer width, fixed at 8'd8.
REQ-013 SHALL have port spi_wrdata, output, 8, the byte to shift.
REQ-014 SHALL have port spi_done, input, 1, a one-cycle pulse from the shifter marking the end of the byte.
REQ-015 SHALL have port busy, output, 1, high from the accepted start through the end of WAIT.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse when the sequence completes.

Function
REQ-017 SHALL implement states IDLE, WREN, GAP, CMD, ADDR, DATA, WAIT, DONE.
REQ-018 SHALL in IDLE with start=1 latch addr/len, assert busy, and go to WREN on the next edge.
REQ-019 SHALL in WREN pulse spi_start once with spi_wrdata=8'h06 and spi_cmd=2'd2, then go to GAP on spi_done.
REQ-020 SHALL hold in GAP for exactly GAP_CYC cycles with no spi_start, then go to CMD.
REQ-021 SHALL in CMD send 8'h02 with spi_cmd=2'd1, then go to ADDR on spi_done.
REQ-022 SHALL in ADDR send addr[23:16], addr[15:8], addr[7:0] in that order, each with spi_cmd=2'd1, then go to DATA.
REQ-023 SHALL in DATA, per byte, pulse data_req, capture wr_data on the following cycle, and pulse spi_start on the cycle after capture.
REQ-024 SHALL drive spi_cmd=2'd1 for every data byte except the last, which uses 2'd2.
REQ-025 SHALL issue each spi_start exactly one cycle after the previous spi_done, except for data bytes, which follow REQ-023 (3 cycles).
REQ-026 SHALL hold spi_wrdata and spi_cmd stable from spi_start until spi_done.
REQ-027 SHALL have only one transfer outstanding at a time; a spi_start while waiting for spi_done is forbidden.
REQ-028 SHALL ignore spi_done when no transfer is outstanding.
REQ-029 SHALL, after the last spi_done, stay in WAIT for TPP_CYC cycles, then go to DONE.
REQ-030 SHALL in DONE pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-031 SHALL ignore start while busy=1; the request is neither queued nor does it alter latched addr/len.
REQ-032 SHALL use a 9-bit byte counter that counts down from the latched len (0 maps to 256) with no wrap.
REQ-033 SHALL NOT change addr across a page boundary; wrapping inside the page is the flash's behaviour.
REQ-034 SHALL keep spi_width=8'd8 in all states.

Reset
REQ-035 SHALL, while rst_n=0, force state IDLE with spi_start=0, spi_cmd=2'd0, spi_wrdata=8'h00, spi_width=8'd8, data_req=0, busy=0, done=0, and all counters 0.
REQ-036 SHALL on reset mid-transfer abandon the sequence, and SHALL NOT act on a spi_done arriving after release until a new start.

Verification
REQ-037 SHALL cover: start with addr=24'h012345, len=4, data A0..A3 -> MOSI byte stream 06 | (GAP_CYC gap) | 02 01 23 45 A0 A1 A2 A3; spi_cmd=2 only on 06 and A3; done once after TPP_CYC.
REQ-038 SHALL cover: len=0 -> exactly 256 data_req pulses and 260 bytes in the PP transaction.
REQ-039 SHALL cover: len=1 -> a single data byte sent with spi_cmd=2'd2.
REQ-040 SHALL cover: start pulsed during ADDR with a new addr -> ignored, and the original addr is programmed.
REQ-041 SHALL cover: rst_n low during DATA byte 2 -> all outputs at reset values next cycle, and a later start runs cleanly from WREN.
REQ-042 SHALL cover: a stray spi_done in IDLE -> no state change and no output pulses.
